output_arbiter: RTL and testbench
=================================

// Module: output_arbiter
// PURPOSE
// - Shares the router's single output port between the three channel FIFOs.
// - Grants a whole packet to one channel at a time, round-robin among channels holding a complete packet.
// - Pops that channel's FIFO byte by byte and drives a req/ack output handshake, then rotates priority.
// - Sits after the per-channel FIFOs; the input side fills the FIFOs, this block drains them.
// PARAMETERS
// - DATA_WIDTH  8  byte width of FIFO and output data
// - DATA_SIZE   6  width of the header size field, header[DATA_SIZE-1:0] = payload byte count
// PORTS
// - clk             in   1               single clock, all logic on posedge
// - rst             in   1               asynchronous, active-high reset
// - fifo_pkt_rdy    in   3               ch i FIFO holds >=1 complete packet
// - fifo_empty      in   3               ch i FIFO empty
// - fifo_rdata      in   3*DATA_WIDTH    first-word-fall-through head data; ch i at [i*DATA_WIDTH +: DATA_WIDTH]
// - fifo_pop        out  3               one-hot, pops head of ch i this cycle
// - ch_en           in   3               config: ch i may be granted
// - crc_en          in   1               config: packet carries one trailing CRC byte
// - data_out        out  DATA_WIDTH     output byte
// - data_out_req    out  1               data_out valid
// - data_out_ack    in   1               sink accepts data_out this cycle
// - grant           out  3               one-hot channel owning the output, 0 when IDLE
// - pkt_done        out  1               1-cycle pulse: last byte of packet accepted
// BEHAVIOUR
// - Reset (async, immediate): all outputs 0; state IDLE; rr pointer = ch0; byte counter 0; output register empty.
// - Transfer rule: a byte moves when data_out_req && data_out_ack.
//   data_out is held stable while data_out_req && !data_out_ack.
// - States: IDLE -> HDR -> BODY -> IDLE.
// - IDLE:
//   - cand[i] = fifo_pkt_rdy[i] & ch_en[i].
//   - If any cand, register grant = first cand searching from the rr pointer upward (mod 3), and latch crc_en.
//   - Go to HDR.
// - Load condition: load = granted && !fifo_empty[g] && (!data_out_req || data_out_ack) && bytes remain.
//   On load, fifo_pop[g] = 1 (combinational, same cycle), data_out <= fifo_rdata[g], data_out_req <= 1.
//   If !load && data_out_ack, data_out_req <= 0.
// - HDR:
//   - On load of the header byte: remaining <= header[DATA_SIZE-1:0] + crc_en_latched.
//   - remaining is DATA_SIZE+1 bits, no overflow.
//   - If remaining would be 0 (size 0, CRC off), go to a drain sub-case: wait for header ack, then finish.
//   - Otherwise go to BODY.
// - BODY:
//   - Each load decrements remaining.
//   - After the load that takes remaining to 0, stop popping.
//   - When that final byte is acked: pkt_done pulse, grant <= 0, rr pointer <= g+1 mod 3, state IDLE.
// - Latency:
//   - cand at cycle 0 in IDLE -> grant valid at cycle 1 -> header popped at cycle 1 -> data_out_req=1 at cycle 2.
//   - With ack held high: one byte per cycle, no bubbles inside a packet.
//   - One idle cycle between packets (IDLE arbitration).
// - Boundaries:
//   - Granted FIFO empty mid-packet (underrun): no pop; data_out_req drops after the pending byte is acked; resume when non-empty.
//   - ch_en or fifo_pkt_rdy changing while granted is ignored until IDLE; crc_en is used as latched at grant.
//   - Single candidate is granted back-to-back regardless of the pointer.
//   - fifo_pop is never asserted for a non-granted channel or when fifo_empty[g] = 1.
// TESTING
// - Reset: assert rst mid-BODY -> data_out_req, fifo_pop, grant, pkt_done = 0 the same cycle; after release, first grant goes to ch0 when all cands are set.
// - Single packet ch1:
//   - Stimulus: header size=3, crc_en=0, ack tied 1.
//   - Response: grant=3'b010; data_out_req high for 4 consecutive cycles starting 2 cycles after pkt_rdy; pkt_done on the 4th byte; 4 pops.
// - Round robin: all three channels ready, each with size=1 packets -> grant order ch0, ch1, ch2, ch0, ...; 1 idle cycle between packets.
// - Back-pressure: ack low for 3 cycles on the 2nd byte -> data_out stable, no pop during stall, byte count unchanged.
// - CRC and size 0:
//   - crc_en=1, size=0 -> 2 bytes sent (header + CRC).
//   - crc_en=0, size=0 -> 1 byte, pkt_done on header ack.
// - Underrun and enable: drive fifo_empty=1 for 2 cycles mid-packet -> req drops after the pending byte, resumes, total byte count correct; ch_en[2]=0 -> ch2 is never granted.

Source files
------------

// File: rtl/output_arbiter.sv
// Output arbiter: grants the shared output port to one channel FIFO for a whole
// packet at a time, round-robin among enabled channels holding a complete packet.

module output_arbiter_chk #(
    parameter int DATA_WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    input logic [2:0]            fifo_pop,
    input logic [2:0]            fifo_empty,
    input logic [2:0]            grant,
    input logic [DATA_WIDTH-1:0] data_out,
    input logic                  data_out_req,
    input logic                  data_out_ack
);

    a_pop_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(fifo_pop));
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_pop_granted: assert property (@(posedge clk) disable iff (rst) (fifo_pop & ~grant) == 3'b000);
    a_pop_not_empty: assert property (@(posedge clk) disable iff (rst) (fifo_pop & fifo_empty) == 3'b000);
    a_hold_stall: assert property (@(posedge clk) disable iff (rst)
        (data_out_req && !data_out_ack) |=> (data_out_req && $stable(data_out)));

endmodule

module output_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              fifo_pkt_rdy,
    input  logic [2:0]              fifo_empty,
    input  logic [3*DATA_WIDTH-1:0] fifo_rdata,
    output logic [2:0]              fifo_pop,
    input  logic [2:0]              ch_en,
    input  logic                    crc_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_out_req,
    input  logic                    data_out_ack,
    output logic [2:0]              grant,
    output logic                    pkt_done
);

    localparam int REM_W = DATA_SIZE + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [2:0]             grant_r;
    logic [1:0]             g_idx_r;
    logic [1:0]             rr_ptr_r;
    logic                   crc_lat_r;
    logic [REM_W-1:0]       remaining_r;
    logic [DATA_WIDTH-1:0]  data_out_r;
    logic                   data_out_req_r;

    logic [2:0]             cand_s;
    logic [2:0]             pick_s;
    logic [DATA_WIDTH-1:0]  head_s;
    logic                   head_empty_s;
    logic                   has_bytes_s;
    logic                   slot_free_s;
    logic                   load_s;
    logic                   final_ack_s;
    logic [REM_W-1:0]       hdr_rem_s;

    // First candidate at or above ptr, wrapping modulo 3; one-hot result.
    function automatic logic [2:0] rr_pick(input logic [2:0] cand, input logic [1:0] ptr);
        logic [2:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = 3'b000;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < 3; k++) begin
            if (!found && cand[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end else begin
                found = found;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return pick;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Head byte and empty flag of the granted channel.
    always_comb begin
        head_s       = fifo_rdata[0 +: DATA_WIDTH];
        head_empty_s = 1'b1;
        case (g_idx_r)
            2'd0: begin
                head_s       = fifo_rdata[0 +: DATA_WIDTH];
                head_empty_s = fifo_empty[0];
            end
            2'd1: begin
                head_s       = fifo_rdata[DATA_WIDTH +: DATA_WIDTH];
                head_empty_s = fifo_empty[1];
            end
            2'd2: begin
                head_s       = fifo_rdata[2*DATA_WIDTH +: DATA_WIDTH];
                head_empty_s = fifo_empty[2];
            end
            default: begin
                head_s       = fifo_rdata[0 +: DATA_WIDTH];
                head_empty_s = 1'b1;
            end
        endcase
    end

    assign hdr_rem_s = {1'b0, head_s[DATA_SIZE-1:0]} + {{DATA_SIZE{1'b0}}, crc_lat_r};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a size-0 packet without CRC enters BODY with nothing left to load.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|cand_s) begin
                    state_nxt_s = ST_HDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (load_s) begin
                    state_nxt_s = ST_BODY;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_BODY: begin
                if (final_ack_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BODY;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Arbitration, load decision, pop strobe and end-of-packet pulse.
    always_comb begin
        cand_s      = fifo_pkt_rdy & ch_en;
        pick_s      = rr_pick(cand_s, rr_ptr_r);
        slot_free_s = !data_out_req_r || data_out_ack;
        case (state_r)
            ST_HDR:  has_bytes_s = 1'b1;
            ST_BODY: has_bytes_s = (remaining_r != {REM_W{1'b0}});
            default: has_bytes_s = 1'b0;
        endcase
        load_s      = has_bytes_s && !head_empty_s && slot_free_s;
        final_ack_s = (state_r == ST_BODY) && (remaining_r == {REM_W{1'b0}}) &&
                      data_out_req_r && data_out_ack;
        fifo_pop    = load_s ? grant_r : 3'b000;
        pkt_done    = final_ack_s;
    end

    // Grant ownership, latched CRC mode and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r   <= 3'b000;
            g_idx_r   <= 2'd0;
            crc_lat_r <= 1'b0;
            rr_ptr_r  <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|cand_s) begin
                        grant_r   <= pick_s;
                        g_idx_r   <= onehot_to_idx(pick_s);
                        crc_lat_r <= crc_en;
                    end
                end
                ST_BODY: begin
                    if (final_ack_s) begin
                        grant_r  <= 3'b000;
                        rr_ptr_r <= (g_idx_r == 2'd2) ? 2'd0 : g_idx_r + 2'd1;
                    end
                end
                default: begin
                    grant_r <= grant_r;
                end
            endcase
        end
    end

    // Bytes still to pop after the header: payload count plus optional CRC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_r <= {REM_W{1'b0}};
        end else if (load_s && (state_r == ST_HDR)) begin
            remaining_r <= hdr_rem_s;
        end else if (load_s && (state_r == ST_BODY)) begin
            remaining_r <= remaining_r - {{DATA_SIZE{1'b0}}, 1'b1};
        end
    end

    // Output byte register and its valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_r     <= {DATA_WIDTH{1'b0}};
            data_out_req_r <= 1'b0;
        end else if (load_s) begin
            data_out_r     <= head_s;
            data_out_req_r <= 1'b1;
        end else if (data_out_ack) begin
            data_out_req_r <= 1'b0;
        end
    end

    assign data_out     = data_out_r;
    assign data_out_req = data_out_req_r;
    assign grant        = grant_r;

    output_arbiter_chk #(.DATA_WIDTH(DATA_WIDTH)) u_chk (
        .clk          (clk),
        .rst          (rst),
        .fifo_pop     (fifo_pop),
        .fifo_empty   (fifo_empty),
        .grant        (grant),
        .data_out     (data_out),
        .data_out_req (data_out_req),
        .data_out_ack (data_out_ack)
    );

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: packet vector table plus hand sequences
// for round robin, back-pressure, underrun, channel enable and mid-packet reset.
module tb_output_arbiter;

    localparam int DW = 8;
    localparam int DS = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      fifo_pkt_rdy;
    logic [2:0]      fifo_empty;
    logic [3*DW-1:0] fifo_rdata;
    logic [2:0]      fifo_pop;
    logic [2:0]      ch_en;
    logic            crc_en;
    logic [DW-1:0]   data_out;
    logic            data_out_req;
    logic            data_out_ack;
    logic [2:0]      grant;
    logic            pkt_done;

    always #5 clk = ~clk;

    output_arbiter #(.DATA_WIDTH(DW), .DATA_SIZE(DS)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_pkt_rdy (fifo_pkt_rdy),
        .fifo_empty   (fifo_empty),
        .fifo_rdata   (fifo_rdata),
        .fifo_pop     (fifo_pop),
        .ch_en        (ch_en),
        .crc_en       (crc_en),
        .data_out     (data_out),
        .data_out_req (data_out_req),
        .data_out_ack (data_out_ack),
        .grant        (grant),
        .pkt_done     (pkt_done)
    );

    typedef struct {
        int         ch;
        int         size;
        bit         crc;
        int         exp_bytes;
        logic [2:0] exp_grant;
        int         exp_first_req;
        int         exp_done_cyc;
    } vec_t;

    vec_t       vecs [5];
    logic [2:0] rr_exp [6];

    logic [7:0] q0[$], q1[$], q2[$];
    logic [7:0] got[$], expq[$];
    logic [2:0] order[$];
    logic [2:0] force_empty;
    logic [2:0] pend_pop;
    logic       s_req, s_done;
    logic [2:0] s_pop, s_grant;
    logic [7:0] s_data;
    int         n_pops;
    int         vectors = 0;
    int         errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic refresh_fifo();
        fifo_empty[0] = (q0.size() == 0) || force_empty[0];
        fifo_empty[1] = (q1.size() == 0) || force_empty[1];
        fifo_empty[2] = (q2.size() == 0) || force_empty[2];
        fifo_pkt_rdy  = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
        fifo_rdata[0 +: 8]  = (q0.size() != 0) ? q0[0] : 8'h00;
        fifo_rdata[8 +: 8]  = (q1.size() != 0) ? q1[0] : 8'h00;
        fifo_rdata[16 +: 8] = (q2.size() != 0) ? q2[0] : 8'h00;
    endtask

    // One clock: drive FIFO view, sample at negedge, apply pops after the edge.
    task automatic cycle();
        logic [7:0] dummy;
        refresh_fifo();
        @(negedge clk);
        s_req   = data_out_req;
        s_done  = pkt_done;
        s_pop   = fifo_pop;
        s_grant = grant;
        s_data  = data_out;
        if (s_req && data_out_ack) got.push_back(s_data);
        pend_pop = s_pop;
        @(posedge clk);
        #1;
        if (pend_pop[0] && q0.size() > 0) dummy = q0.pop_front();
        if (pend_pop[1] && q1.size() > 0) dummy = q1.pop_front();
        if (pend_pop[2] && q2.size() > 0) dummy = q2.pop_front();
        n_pops += $countones(pend_pop);
    endtask

    task automatic push_byte(input int ch, input logic [7:0] b);
        case (ch)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    task automatic push_pkt(input int ch, input int size, input bit crc, input bit track);
        logic [7:0] b;
        int n;
        n = size + 1 + (crc ? 1 : 0);
        for (int j = 0; j < n; j++) begin
            if (j == 0) b = 8'(size);
            else if (j <= size) b = 8'((ch * 16) + j);
            else b = 8'(8'hC0 + ch);
            push_byte(ch, b);
            if (track) expq.push_back(b);
        end
    endtask

    task automatic check_data(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (i >= expq.size() || got[i] != expq[i]) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_req, done_cyc, req_cnt, done_cnt, gap_cnt, stall, stall_pops, stall_bad;
        int fcnt, low_cnt, forced_pops, body_seen;
        logic [2:0] seen_grant, prev_grant, first_g;

        vecs[0] = '{1, 3,  1'b0, 4,  3'b010, 2, 5};
        vecs[1] = '{0, 0,  1'b1, 2,  3'b001, 2, 3};
        vecs[2] = '{2, 0,  1'b0, 1,  3'b100, 2, 2};
        vecs[3] = '{0, 5,  1'b1, 7,  3'b001, 2, 8};
        vecs[4] = '{2, 63, 1'b1, 65, 3'b100, 2, 66};
        rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        rst          = 1'b1;
        ch_en        = 3'b111;
        crc_en       = 1'b0;
        data_out_ack = 1'b0;
        force_empty  = 3'b000;
        pend_pop     = 3'b000;
        n_pops       = 0;
        refresh_fifo();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        cycle();
        check("reset_req", int'(s_req), 0);
        check("reset_grant", int'(s_grant), 0);
        check("reset_pop", int'(s_pop), 0);
        check("reset_done", int'(s_done), 0);
        check("reset_data", int'(s_data), 0);

        // Packet vector table, ack held high.
        data_out_ack = 1'b1;
        for (int v = 0; v < 5; v++) begin
            crc_en = vecs[v].crc;
            got.delete();
            expq.delete();
            push_pkt(vecs[v].ch, vecs[v].size, vecs[v].crc, 1'b1);
            n_pops = 0; first_req = -1; done_cyc = -1; req_cnt = 0; seen_grant = 3'b000;
            for (int c = 0; c < 200 && done_cyc < 0; c++) begin
                cycle();
                if (s_req && first_req < 0) first_req = c;
                if (s_req) req_cnt++;
                seen_grant |= s_grant;
                if (s_done) done_cyc = c;
            end
            cycle();
            check($sformatf("vec%0d_grant", v), int'(seen_grant), int'(vecs[v].exp_grant));
            check($sformatf("vec%0d_bytes", v), got.size(), vecs[v].exp_bytes);
            check($sformatf("vec%0d_pops", v), n_pops, vecs[v].exp_bytes);
            check($sformatf("vec%0d_first_req", v), first_req, vecs[v].exp_first_req);
            check($sformatf("vec%0d_done_cycle", v), done_cyc, vecs[v].exp_done_cyc);
            check($sformatf("vec%0d_req_cycles", v), req_cnt, vecs[v].exp_bytes);
            check($sformatf("vec%0d_grant_released", v), int'(s_grant), 0);
            check_data($sformatf("vec%0d_data", v));
        end

        // Round robin: two size-1 packets per channel.
        crc_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_pkt(0, 1, 1'b0, 1'b0);
            push_pkt(1, 1, 1'b0, 1'b0);
            push_pkt(2, 1, 1'b0, 1'b0);
        end
        order.delete();
        prev_grant = 3'b000; done_cnt = 0; gap_cnt = 0;
        for (int c = 0; c < 100 && done_cnt < 6; c++) begin
            cycle();
            if (s_grant != 3'b000 && prev_grant == 3'b000) order.push_back(s_grant);
            if (s_grant == 3'b000 && order.size() > 0) gap_cnt++;
            if (s_done) done_cnt++;
            prev_grant = s_grant;
        end
        cycle();
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_order%0d", k), (order.size() > k) ? int'(order[k]) : -1, int'(rr_exp[k]));
        end
        check("rr_done_count", done_cnt, 6);
        check("rr_idle_gaps", gap_cnt, 5);

        // Back-pressure: ack low for 3 cycles while the 2nd byte is presented.
        got.delete(); expq.delete();
        push_pkt(1, 3, 1'b0, 1'b1);
        n_pops = 0; done_cyc = -1; stall = 0; stall_pops = 0; stall_bad = 0;
        for (int c = 0; c < 60 && done_cyc < 0; c++) begin
            data_out_ack = (got.size() == 1 && stall < 3) ? 1'b0 : 1'b1;
            cycle();
            if (!data_out_ack && s_req) begin
                stall++;
                if (s_pop != 3'b000) stall_pops++;
                if (s_data != expq[1]) stall_bad++;
            end
            if (s_done) done_cyc = c;
        end
        data_out_ack = 1'b1;
        cycle();
        check("bp_stall_cycles", stall, 3);
        check("bp_pops_in_stall", stall_pops, 0);
        check("bp_data_stable", stall_bad, 0);
        check("bp_bytes", got.size(), 4);
        check("bp_done_cycle", done_cyc, 8);
        check_data("bp_data");

        // Underrun: granted FIFO reads empty for 2 cycles after two pops.
        got.delete(); expq.delete();
        push_pkt(0, 4, 1'b0, 1'b1);
        n_pops = 0; fcnt = 0; first_req = -1; done_cyc = -1; low_cnt = 0; forced_pops = 0;
        for (int c = 0; c < 60 && done_cyc < 0; c++) begin
            force_empty = (n_pops >= 2 && fcnt < 2) ? 3'b001 : 3'b000;
            if (force_empty != 3'b000) fcnt++;
            cycle();
            if (force_empty != 3'b000 && s_pop != 3'b000) forced_pops++;
            if (s_req && first_req < 0) first_req = c;
            if (!s_req && first_req >= 0) low_cnt++;
            if (s_done) done_cyc = c;
        end
        force_empty = 3'b000;
        cycle();
        check("ur_forced_cycles", fcnt, 2);
        check("ur_pops_while_empty", forced_pops, 0);
        check("ur_req_low_cycles", low_cnt, 2);
        check("ur_bytes", got.size(), 5);
        check("ur_done_cycle", done_cyc, 8);
        check_data("ur_data");

        // Channel enable: ch2 holds a packet but is disabled.
        ch_en = 3'b011;
        push_pkt(2, 1, 1'b0, 1'b0);
        push_pkt(0, 2, 1'b0, 1'b0);
        seen_grant = 3'b000; done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            seen_grant |= s_grant;
            if (s_done) done_cnt++;
        end
        check("en_ch2_never_granted", int'(seen_grant[2]), 0);
        check("en_ch2_untouched", q2.size(), 2);
        check("en_ch0_done", done_cnt, 1);
        ch_en = 3'b111;
        seen_grant = 3'b000; done_cnt = 0;
        for (int c = 0; c < 30 && done_cnt < 1; c++) begin
            cycle();
            seen_grant |= s_grant;
            if (s_done) done_cnt++;
        end
        cycle();
        check("en_ch2_granted_after_enable", int'(seen_grant), 4);

        // Reset mid-BODY of ch1 while the pointer sits past ch0.
        push_pkt(0, 1, 1'b0, 1'b0);
        push_pkt(1, 5, 1'b0, 1'b0);
        body_seen = 0;
        for (int c = 0; c < 40 && body_seen < 2; c++) begin
            cycle();
            if (s_grant == 3'b010 && s_req) body_seen++;
        end
        check("rst_reached_body", body_seen, 2);
        rst = 1'b1;
        #1;
        check("rst_async_req", int'(data_out_req), 0);
        check("rst_async_pop", int'(fifo_pop), 0);
        check("rst_async_grant", int'(grant), 0);
        check("rst_async_done", int'(pkt_done), 0);
        q0.delete(); q1.delete(); q2.delete();
        pend_pop = 3'b000;
        repeat (2) @(posedge clk);
        push_pkt(0, 1, 1'b0, 1'b0);
        push_pkt(1, 1, 1'b0, 1'b0);
        push_pkt(2, 1, 1'b0, 1'b0);
        #1 rst = 1'b0;
        first_g = 3'b000;
        for (int c = 0; c < 10 && first_g == 3'b000; c++) begin
            cycle();
            first_g = s_grant;
        end
        check("rst_first_grant_ch0", int'(first_g), 1);
        done_cnt = 0;
        for (int c = 0; c < 60 && done_cnt < 3; c++) begin
            cycle();
            if (s_done) done_cnt++;
        end
        check("rst_post_done_count", done_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
